// File: rtl/seg_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : seg_scan_driver                                        |
// | Description : 8-digit multiplexed seven-segment driver with a        |
// |               per-frame shadow word, anode dead-time, leading-zero   |
// |               blanking and per-digit decimal points. Active-low pins.|
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module seg_scan_driver #(
  parameter int SCAN_DIV = 100000,
  parameter int DEAD     = 4
) (
  input  logic        clk_in,
  input  logic        RST,
  input  logic [31:0] data,
  input  logic        hold,
  input  logic        blank_lz,
  input  logic [7:0]  dp_mask,
  output logic [7:0]  SEG,
  output logic [7:0]  AN
);

  localparam logic [19:0] c_TICK_AT = 20'(SCAN_DIV - 1);
  localparam logic [19:0] c_DEAD    = 20'(DEAD);

  logic [19:0] r_cnt;
  logic [2:0]  r_idx;
  logic [19:0] r_dead;
  logic [31:0] r_shadow;
  logic        r_first;

  logic        w_tick;
  logic [19:0] w_cnt_n;
  logic [2:0]  w_idx_n;
  logic [19:0] w_dead_n;
  logic [31:0] w_shadow_n;
  logic [3:0]  w_nibble;
  logic        w_blank;
  logic [7:0]  w_an_n;
  logic [7:0]  w_seg_n;

  // Hex nibble to g..a segment pattern (active low).
  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  // Next-state values; outputs are derived from these so SEG/AN move on
  // the same edge as the digit index.
  always_comb begin
    w_tick     = (r_cnt == c_TICK_AT);
    w_cnt_n    = w_tick ? 20'd0 : r_cnt + 20'd1;
    w_idx_n    = w_tick ? r_idx + 3'd1 : r_idx;
    w_dead_n   = r_dead;
    if (w_tick)
      w_dead_n = c_DEAD;
    else if (r_dead != 20'd0)
      w_dead_n = r_dead - 20'd1;
    // Loads only at frame boundaries (or right after reset) keep the
    // displayed word consistent across all eight digits of a frame.
    w_shadow_n = r_shadow;
    if (!hold && (r_first || (w_tick && r_idx == 3'd7)))
      w_shadow_n = data;
    w_nibble   = w_shadow_n[{w_idx_n, 2'b00} +: 4];
    w_blank    = blank_lz && (w_idx_n != 3'd0) &&
                 ((w_shadow_n >> {w_idx_n, 2'b00}) == 32'd0);
    w_an_n     = (w_dead_n != 20'd0 || w_blank) ? 8'hFF
                                                : ~(8'd1 << w_idx_n);
    w_seg_n    = w_blank ? 8'hFF : {~dp_mask[w_idx_n], glyph(w_nibble)};
  end

  // Scan state and registered pin drivers.
  always_ff @(posedge clk_in or posedge RST) begin
    if (RST) begin
      r_cnt    <= 20'd0;
      r_idx    <= 3'd0;
      r_dead   <= c_DEAD;
      r_shadow <= 32'd0;
      r_first  <= 1'b1;
      SEG      <= 8'hFF;
      AN       <= 8'hFF;
    end else begin
      r_cnt    <= w_cnt_n;
      r_idx    <= w_idx_n;
      r_dead   <= w_dead_n;
      r_shadow <= w_shadow_n;
      r_first  <= 1'b0;
      SEG      <= w_seg_n;
      AN       <= w_an_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_seg_scan_driver                                     |
// | Description : Self-checking bench for seg_scan_driver: cycle model  |
// |               compared every edge plus hand-computed pin values.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_seg_scan_driver;

  localparam int S = 4;
  localparam int D = 1;

  logic        clk = 1'b0;
  logic        RST;
  logic [31:0] data;
  logic        hold;
  logic        blank_lz;
  logic [7:0]  dp_mask;
  logic [7:0]  SEG;
  logic [7:0]  AN;

  int total = 0;
  int bad   = 0;
  int n     = 0;
  logic [31:0] m_shadow;

  seg_scan_driver #(.SCAN_DIV(S), .DEAD(D)) dut (
    .clk_in  (clk),
    .RST     (RST),
    .data    (data),
    .hold    (hold),
    .blank_lz(blank_lz),
    .dp_mask (dp_mask),
    .SEG     (SEG),
    .AN      (AN)
  );

  // 10-unit board clock.
  always #5 clk = ~clk;

  function automatic logic [6:0] gl(input logic [3:0] v);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[v];
  endfunction

  // Expected {AN,SEG} after edge e since reset release, from slot arithmetic.
  function automatic logic [15:0] model(input int e, input logic [31:0] sh,
                                        input logic blz, input logic [7:0] dp);
    int d, p;
    logic bl;
    logic [3:0] nib;
    logic [7:0] an, seg;
    if (e == 0) return 16'hFFFF;
    d   = (e / S) % 8;
    p   = e % S;
    bl  = blz && (d > 0) && ((sh >> (4 * d)) == 32'd0);
    nib = sh[4 * d +: 4];
    an  = (p < D || bl) ? 8'hFF : ~(8'd1 << d);
    seg = bl ? 8'hFF : {~dp[d], gl(nib)};
    return {an, seg};
  endfunction

  task automatic check(input string name, input logic [7:0] exp_an,
                       input logic [7:0] exp_seg);
    total++;
    if (AN !== exp_an || SEG !== exp_seg) begin
      bad++;
      $display("FAIL %s edge=%0d: AN=%h SEG=%h, required AN=%h SEG=%h",
               name, n, AN, SEG, exp_an, exp_seg);
    end
  endtask

  task automatic to_edge(input int k);
    int guard = 0;
    while (n < k && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (n != k) begin
      total++;
      bad++;
      $display("FAIL to_edge: reached edge %0d, required %0d", n, k);
    end
  endtask

  initial begin
    RST = 1'b1; data = 32'h0; hold = 1'b0; blank_lz = 1'b0; dp_mask = 8'h00;
    m_shadow = 32'h0;
    fork
      // Model and every-edge compare.
      begin
        logic blz_s;
        logic [7:0] dp_s;
        logic [15:0] e;
        forever begin
          @(posedge clk);
          if (RST) begin
            n = 0;
            m_shadow = 32'h0;
          end else begin
            n++;
            if (!hold && (n == 1 || n % (8 * S) == 0)) m_shadow = data;
          end
          blz_s = blank_lz;
          dp_s  = dp_mask;
          #1;
          e = model(n, m_shadow, blz_s, dp_s);
          check("model", e[15:8], e[7:0]);
        end
      end
      // Directed stimulus with hand-computed pins.
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          data = (i % 2 == 0) ? 32'hA5A5A5A5 : 32'h5A5A5A5A;
          check("reset", 8'hFF, 8'hFF);
        end
        @(negedge clk);
        data = 32'h12345678;
        RST  = 1'b0;
        to_edge(1);  check("first_digit", 8'hFE, 8'h80);
        to_edge(4);  check("dead_time",   8'hFF, 8'hF8);
        to_edge(5);  check("digit1",      8'hFD, 8'hF8);
        to_edge(9);  check("digit2",      8'hFB, 8'h82);
        to_edge(10); data = 32'hFFFFFFFF;
        to_edge(13); check("tear_free3",  8'hF7, 8'h92);
        to_edge(29); check("tear_free7",  8'h7F, 8'hF9);
        to_edge(33); check("new_frame0",  8'hFE, 8'h8E);
        to_edge(37); check("new_frame1",  8'hFD, 8'h8E);
        data = 32'h00000A00; blank_lz = 1'b1;
        to_edge(65); check("lz_d0",       8'hFE, 8'hC0);
        to_edge(69); check("lz_d1",       8'hFD, 8'hC0);
        to_edge(73); check("lz_d2",       8'hFB, 8'h88);
        to_edge(77); check("lz_d3_blank", 8'hFF, 8'hFF);
        to_edge(93); check("lz_d7_blank", 8'hFF, 8'hFF);
        data = 32'h0;
        to_edge(97);  check("zero_d0",    8'hFE, 8'hC0);
        to_edge(101); check("zero_d1",    8'hFF, 8'hFF);
        data = 32'h87654321; blank_lz = 1'b0; dp_mask = 8'h04;
        to_edge(137); check("dp_d2",      8'hFB, 8'h30);
        hold = 1'b1; data = 32'hDEADBEEF;
        to_edge(161); check("hold_f1",    8'hFE, 8'hF9);
        to_edge(193); check("hold_f2",    8'hFE, 8'hF9);
        to_edge(200); hold = 1'b0;
        to_edge(217); check("unhold_mid", 8'hBF, 8'hF8);
        to_edge(225); check("unhold_d0",  8'hFE, 8'h8E);
        to_edge(233); check("unhold_d2",  8'hFB, 8'h06);
        to_edge(245);
        data = 32'h11111111;
        RST  = 1'b1;
        #1;
        check("async_reset", 8'hFF, 8'hFF);
        @(negedge clk);
        RST = 1'b0;
        to_edge(1);  check("restart_d0",  8'hFE, 8'hF9);
        to_edge(4);  check("restart_dead", 8'hFF, 8'hF9);
        to_edge(9);  check("restart_d2",  8'hFB, 8'h79);
        to_edge(12);
      end
    join_any
    disable fork;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
